pt_frame_loader: RTL and testbench

//  Upstream feeder for the PT2262 encoder: collects 3 UART bytes into one 24-bit code word (12 two-bit code bits).

---
 rtl/pt_frame_loader.sv | 164 ++++++++++++++++
 tb/tb_pt_frame_loader.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pt_frame_loader.sv
// pt_frame_loader: assembles three UART bytes into a 24-bit PT2262 code word.
// Each byte is one third of the word, and each two-bit pair is one code bit.
// The block rejects words that contain the reserved pair 11.
// An accepted word is loaded into the encoder REPEATS times back-to-back.
// A partial word is dropped if the next byte takes too long to arrive.
module pt_frame_loader #(
    parameter int REPEATS     = 4,
    parameter int TIMEOUT_CYC = 1000000,
    parameter int TO_W        = 20
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_data_i,
    input  logic        enc_done_i,
    output logic        enc_ld_o,
    output logic [23:0] enc_ad_o,
    output logic        busy_o,
    output logic        word_done_o,
    output logic        frame_err_o,
    output logic        overrun_o
);

    typedef enum logic [1:0] {
        COLLECT,
        ARM,
        SETTLE,
        SEND
    } state_e;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    state_e          state_q;
    logic [1:0]      byte_cnt_q;
    logic [7:0]      rep_cnt_q;
    logic [TO_W-1:0] to_cnt_q;
    logic [15:0]     word_q;
    logic            enc_ld_q;
    logic [23:0]     enc_ad_q;
    logic            busy_q;
    logic            word_done_q;
    logic            frame_err_q;
    logic            overrun_q;

    logic [23:0]     word_d;
    logic            pair_bad_d;
    logic [8:0]      rep_next_d;
    logic            last_rep_d;

    // The candidate word is the two held bytes plus the incoming byte; flag any reserved 11 pair and the final repeat.
    always_comb begin
        word_d     = {word_q, rx_data_i};
        pair_bad_d = 1'b0;
        for (int i = 0; i < 12; i++) begin
            pair_bad_d = pair_bad_d | (word_d[2*i+1] & word_d[2*i]);
        end
        rep_next_d = {1'b0, rep_cnt_q} + 9'd1;
        last_rep_d = (rep_next_d >= 9'(REPEATS));
    end

    // Controller FSM: byte assembly, inter-byte timeout, and the load/settle/send handshake with the encoder.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= COLLECT;
            byte_cnt_q  <= 2'd0;
            rep_cnt_q   <= 8'd0;
            to_cnt_q    <= '0;
            word_q      <= 16'd0;
            enc_ld_q    <= 1'b0;
            enc_ad_q    <= 24'd0;
            busy_q      <= 1'b0;
            word_done_q <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            enc_ld_q    <= 1'b0;
            word_done_q <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= rx_valid_i && (state_q != COLLECT);

            case (state_q)
                COLLECT: begin
                    if (rx_valid_i) begin
                        to_cnt_q <= '0;
                        case (byte_cnt_q)
                            2'd0: begin
                                word_q[15:8] <= rx_data_i;
                                byte_cnt_q   <= 2'd1;
                            end
                            2'd1: begin
                                word_q[7:0] <= rx_data_i;
                                byte_cnt_q  <= 2'd2;
                            end
                            default: begin
                                byte_cnt_q <= 2'd0;
                                if (pair_bad_d) begin
                                    frame_err_q <= 1'b1;
                                end else begin
                                    enc_ad_q  <= word_d;
                                    busy_q    <= 1'b1;
                                    rep_cnt_q <= 8'd0;
                                    if (enc_done_i) begin
                                        enc_ld_q <= 1'b1;
                                        state_q  <= SETTLE;
                                    end else begin
                                        state_q <= ARM;
                                    end
                                end
                            end
                        endcase
                    end else if (byte_cnt_q != 2'd0) begin
                        if (to_cnt_q == TO_LAST) begin
                            byte_cnt_q <= 2'd0;
                            to_cnt_q   <= '0;
                        end else begin
                            to_cnt_q <= to_cnt_q + 1'b1;
                        end
                    end else begin
                        to_cnt_q <= '0;
                    end
                end

                ARM: begin
                    if (enc_done_i) begin
                        enc_ld_q <= 1'b1;
                        state_q  <= SETTLE;
                    end
                end

                SETTLE: begin
                    if (!enc_done_i) begin
                        state_q <= SEND;
                    end
                end

                SEND: begin
                    if (enc_done_i) begin
                        rep_cnt_q <= rep_next_d[7:0];
                        if (last_rep_d) begin
                            word_done_q <= 1'b1;
                            busy_q      <= 1'b0;
                            state_q     <= COLLECT;
                        end else begin
                            enc_ld_q <= 1'b1;
                            state_q  <= SETTLE;
                        end
                    end
                end

                default: begin
                    state_q <= COLLECT;
                end
            endcase
        end
    end

    assign enc_ld_o    = enc_ld_q;
    assign enc_ad_o    = enc_ad_q;
    assign busy_o      = busy_q;
    assign word_done_o = word_done_q;
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_pt_frame_loader.sv
// tb_pt_frame_loader: scoreboard bench for pt_frame_loader.
// It includes an encoder model whose frame lasts 512 cycles from each load.
module tb_pt_frame_loader;

    localparam int REPEATS     = 4;
    localparam int TIMEOUT_CYC = 50;
    localparam int TO_W        = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        enc_done;
    logic        enc_ld;
    logic [23:0] enc_ad;
    logic        busy;
    logic        word_done;
    logic        frame_err;
    logic        overrun;

    logic        model_done = 1'b1;
    int          frame_left = 0;
    logic        hold_low;

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          ld_count = 0;
    int          last_ld_cyc = 0;

    logic [23:0] exp_ad_q[$];
    int          exp_gap_q[$];
    logic [23:0] exp_wd_q[$];
    logic [23:0] exp_fe_q[$];
    logic [23:0] exp_ov_q[$];

    pt_frame_loader #(
        .REPEATS    (REPEATS),
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .TO_W       (TO_W)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .rx_valid_i (rx_valid),
        .rx_data_i  (rx_data),
        .enc_done_i (enc_done),
        .enc_ld_o   (enc_ld),
        .enc_ad_o   (enc_ad),
        .busy_o     (busy),
        .word_done_o(word_done),
        .frame_err_o(frame_err),
        .overrun_o  (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Encoder model: done drops the cycle after a load and rises 512 cycles after the load; it ignores rst.
    always @(posedge clk) begin
        if (enc_ld) begin
            model_done <= 1'b0;
            frame_left <= 511;
        end else if (frame_left > 0) begin
            frame_left <= frame_left - 1;
            if (frame_left == 1) model_done <= 1'b1;
        end
    end

    assign enc_done = model_done & ~hold_low;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: every output pulse pops the matching expectation and checks it.
    always @(negedge clk) begin
        if (enc_ld === 1'b1) begin
            ld_count++;
            if (exp_ad_q.size() == 0) begin
                checkOutput("unexpected_enc_ld", 32'd1, 32'd0);
            end else begin
                automatic logic [23:0] ad  = exp_ad_q.pop_front();
                automatic int          gap = exp_gap_q.pop_front();
                checkOutput("enc_ad_at_ld", {8'd0, enc_ad}, {8'd0, ad});
                if (gap != 0) checkOutput("ld_spacing", cyc - last_ld_cyc, gap);
            end
            last_ld_cyc = cyc;
        end
        if (word_done === 1'b1) begin
            if (exp_wd_q.size() == 0) begin
                checkOutput("unexpected_word_done", 32'd1, 32'd0);
            end else begin
                automatic logic [23:0] ad = exp_wd_q.pop_front();
                checkOutput("word_done_enc_ad", {8'd0, enc_ad}, {8'd0, ad});
                checkOutput("word_done_busy", {31'd0, busy}, 32'd0);
            end
        end
        if (frame_err === 1'b1) begin
            if (exp_fe_q.size() == 0) begin
                checkOutput("unexpected_frame_err", 32'd1, 32'd0);
            end else begin
                automatic logic [23:0] ad = exp_fe_q.pop_front();
                checkOutput("frame_err_enc_ad", {8'd0, enc_ad}, {8'd0, ad});
                checkOutput("frame_err_busy", {31'd0, busy}, 32'd0);
            end
        end
        if (overrun === 1'b1) begin
            if (exp_ov_q.size() == 0) begin
                checkOutput("unexpected_overrun", 32'd1, 32'd0);
            end else begin
                automatic logic [23:0] ad = exp_ov_q.pop_front();
                checkOutput("overrun_enc_ad", {8'd0, enc_ad}, {8'd0, ad});
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic expectWord(input logic [23:0] ad, input int loads, input logic with_done);
        for (int i = 0; i < loads; i++) begin
            exp_ad_q.push_back(ad);
            exp_gap_q.push_back(i == 0 ? 0 : 513);
        end
        if (with_done) exp_wd_q.push_back(ad);
    endtask

    task automatic waitIdle(input string name, input int limit);
        int n = 0;
        while (busy === 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, {31'd0, busy}, 32'd0);
    endtask

    task automatic waitLd(input string name, input int limit);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (enc_ld !== 1'b1 && n < limit);
        checkOutput(name, {31'd0, enc_ld}, 32'd1);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_enc_ld"},    {31'd0, enc_ld},    32'd0);
        checkOutput({tag, "_enc_ad"},    {8'd0, enc_ad},     32'd0);
        checkOutput({tag, "_busy"},      {31'd0, busy},      32'd0);
        checkOutput({tag, "_word_done"}, {31'd0, word_done}, 32'd0);
        checkOutput({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
        checkOutput({tag, "_overrun"},   {31'd0, overrun},   32'd0);
    endtask

    initial begin
        int start;
        int early;
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'd0;
        hold_low = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkAllZero("reset");

        // Test 1: basic word, four loads 513 cycles apart
        $display("[TB] test 1: word 0x55009A");
        expectWord(24'h55009A, 4, 1'b1);
        start = ld_count;
        applyStimulus(8'h55);
        applyStimulus(8'h00);
        applyStimulus(8'h9A);
        checkOutput("t1_busy_high", {31'd0, busy}, 32'd1);
        checkOutput("t1_first_ld_latency", {31'd0, enc_ld}, 32'd1);
        waitIdle("t1_idle", 5000);
        checkOutput("t1_ld_count", ld_count - start, 4);

        // Test 2: invalid pair rejected, then a valid word
        $display("[TB] test 2: invalid word then valid word");
        exp_fe_q.push_back(24'h55009A);
        applyStimulus(8'h01);
        applyStimulus(8'h02);
        applyStimulus(8'h03);
        checkOutput("t2_busy_low", {31'd0, busy}, 32'd0);
        @(negedge clk);
        expectWord(24'h121046, 4, 1'b1);
        start = ld_count;
        applyStimulus(8'h12);
        applyStimulus(8'h10);
        applyStimulus(8'h46);
        waitIdle("t2_idle", 5000);
        checkOutput("t2_ld_count", ld_count - start, 4);

        // Test 3: partial word dropped by timeout
        $display("[TB] test 3: timeout drops partial word");
        applyStimulus(8'hAA);
        applyStimulus(8'hAA);
        repeat (TIMEOUT_CYC + 10) @(negedge clk);
        expectWord(24'h112244, 4, 1'b1);
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        applyStimulus(8'h44);
        waitIdle("t3_idle", 5000);

        // Test 4: byte during the second load is an overrun
        $display("[TB] test 4: overrun at second load");
        expectWord(24'h102040, 4, 1'b1);
        exp_ov_q.push_back(24'h102040);
        start = ld_count;
        applyStimulus(8'h10);
        applyStimulus(8'h20);
        applyStimulus(8'h40);
        checkOutput("t4_ld1", {31'd0, enc_ld}, 32'd1);
        waitLd("t4_ld2", 1000);
        rx_valid = 1'b1;
        rx_data  = 8'h77;
        @(negedge clk);
        rx_valid = 1'b0;
        checkOutput("t4_overrun_pulse", {31'd0, overrun}, 32'd1);
        waitIdle("t4_idle", 5000);
        checkOutput("t4_ld_count", ld_count - start, 4);

        // Test 5: encoder held busy at accept
        $display("[TB] test 5: delayed enc_done");
        hold_low = 1'b1;
        expectWord(24'h050505, 4, 1'b1);
        applyStimulus(8'h05);
        applyStimulus(8'h05);
        applyStimulus(8'h05);
        early = 0;
        for (int i = 0; i < 100; i++) begin
            if (enc_ld === 1'b1) early++;
            @(negedge clk);
        end
        checkOutput("t5_no_early_ld", early, 0);
        hold_low = 1'b0;
        checkOutput("t5_ld_low_at_rise", {31'd0, enc_ld}, 32'd0);
        @(negedge clk);
        checkOutput("t5_ld_after_rise", {31'd0, enc_ld}, 32'd1);
        waitIdle("t5_idle", 5000);

        // Test 6: reset during the second repeat
        $display("[TB] test 6: reset mid-word");
        expectWord(24'h111111, 2, 1'b0);
        applyStimulus(8'h11);
        applyStimulus(8'h11);
        applyStimulus(8'h11);
        waitLd("t6_ld2", 1000);
        repeat (100) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkAllZero("t6_after_rst");
        repeat (1000) @(negedge clk);
        expectWord(24'h150115, 4, 1'b1);
        start = ld_count;
        applyStimulus(8'h15);
        applyStimulus(8'h01);
        applyStimulus(8'h15);
        waitIdle("t6_idle", 5000);
        checkOutput("t6_ld_count", ld_count - start, 4);

        repeat (5) @(negedge clk);
        checkOutput("left_enc_ld",    exp_ad_q.size(), 0);
        checkOutput("left_word_done", exp_wd_q.size(), 0);
        checkOutput("left_frame_err", exp_fe_q.size(), 0);
        checkOutput("left_overrun",   exp_ov_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
